// File: rtl/tick_gen_if.sv
// tick_gen_if: memory-style request/response bus between a host and tick_gen
interface tick_gen_if;
   logic        tick_valid;
   logic [31:0] tick_addr;
   logic [31:0] tick_wdata;
   logic [3:0]  tick_wstrb;
   logic [31:0] tick_rdata;
   logic        tick_ready;
   modport master (
      output tick_valid, tick_addr, tick_wdata, tick_wstrb,
      input  tick_rdata, tick_ready
   );
   modport slave (
      input  tick_valid, tick_addr, tick_wdata, tick_wstrb,
      output tick_rdata, tick_ready
   );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: run-time programmable multi-channel tick/toggle generator.
// Define TICK_GEN_IRQ_EN to add sticky per-channel PEND/IE bits and tick_irq.
module tick_gen #(
   parameter int NUM_CH    = 2,
   parameter int DIV_WIDTH = 16,
   parameter int DIV0_RST  = 380,
   parameter int DIVN_RST  = 216
) (
   input  logic              clock,
   input  logic              reset,
   tick_gen_if.slave         bus,
   output logic [NUM_CH-1:0] tick_pulse,
   output logic [NUM_CH-1:0] tick_toggle,
   output logic              tick_irq
);
   logic [2:0]  ch_idx;
   logic        sel_ctrl;
   logic        wr;
   logic        rd;
   logic [31:0] wmask;
   logic [31:0] rd_val [NUM_CH];
   logic [31:0] rd_mux;
   logic        unused_addr;
   // channel field spans the 8-channel maximum so unpopulated slots decode as out of range
   assign ch_idx      = bus.tick_addr[5:3];
   assign sel_ctrl    = bus.tick_addr[2];
   assign wr          = bus.tick_valid && (|bus.tick_wstrb);
   assign rd          = bus.tick_valid && !(|bus.tick_wstrb);
   assign wmask       = {{8{bus.tick_wstrb[3]}}, {8{bus.tick_wstrb[2]}},
                         {8{bus.tick_wstrb[1]}}, {8{bus.tick_wstrb[0]}}};
   assign unused_addr = ^{bus.tick_addr[31:6], bus.tick_addr[1:0]};
`ifdef TICK_GEN_IRQ_EN
   logic [NUM_CH-1:0] irq_src;
`endif
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [DIV_WIDTH-1:0] DIV_INIT = DIV_WIDTH'(c == 0 ? DIV0_RST : DIVN_RST);
      logic [DIV_WIDTH-1:0] div;
      logic [DIV_WIDTH-1:0] cnt;
      logic [DIV_WIDTH-1:0] cnt_nxt;
      logic                 en;
      logic                 en_nxt;
      logic                 oneshot;
      logic                 tog;
      logic                 pulse;
      logic                 hit;
      logic                 wr_div;
      logic                 wr_ctrl;
      logic                 term;
      logic                 fire;
      assign hit     = ch_idx == 3'(c);
      assign wr_div  = wr && hit && !sel_ctrl;
      assign wr_ctrl = wr && hit && sel_ctrl && bus.tick_wstrb[0];
      assign term    = en && (cnt == div);
      // a DIV write or an EN-clearing CTRL write on the terminal edge swallows the tick
      assign fire    = term && !wr_div && !(wr_ctrl && !bus.tick_wdata[0]);
      always_comb begin
         en_nxt  = wr_ctrl ? bus.tick_wdata[0] : en && !(fire && oneshot);
         cnt_nxt = (wr_div || !en || !en_nxt || term) ? '0 : cnt + DIV_WIDTH'(1);
      end
      always_ff @(posedge clock or posedge reset)
         if (reset) begin
            div     <= DIV_INIT;
            cnt     <= '0;
            en      <= 1'b1;
            oneshot <= 1'b0;
            tog     <= 1'b0;
            pulse   <= 1'b0;
         end else begin
            if (wr_div) div <= DIV_WIDTH'((32'(div) & ~wmask) | (bus.tick_wdata & wmask));
            if (wr_ctrl) oneshot <= bus.tick_wdata[1];
            en    <= en_nxt;
            cnt   <= cnt_nxt;
            pulse <= fire;
            tog   <= tog ^ fire;
         end
      assign tick_pulse[c]  = pulse;
      assign tick_toggle[c] = tog;
`ifdef TICK_GEN_IRQ_EN
      logic pend;
      logic ie;
      always_ff @(posedge clock or posedge reset)
         if (reset) begin
            pend <= 1'b0;
            ie   <= 1'b0;
         end else begin
            pend <= fire || (pend && !(wr_ctrl && bus.tick_wdata[3]));
            if (wr_ctrl) ie <= bus.tick_wdata[4];
         end
      assign irq_src[c] = pend && ie;
      assign rd_val[c]  = sel_ctrl ? {27'd0, ie, pend, tog, oneshot, en} : 32'(div);
`else
      assign rd_val[c]  = sel_ctrl ? {29'd0, tog, oneshot, en} : 32'(div);
`endif
   end
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) rd_mux = (ch_idx == 3'(i)) ? rd_val[i] : rd_mux;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         bus.tick_ready <= 1'b0;
         bus.tick_rdata <= '0;
      end else begin
         bus.tick_ready <= bus.tick_valid;
         bus.tick_rdata <= rd ? rd_mux : '0;
      end
`ifdef TICK_GEN_IRQ_EN
   always_ff @(posedge clock or posedge reset)
      if (reset) tick_irq <= 1'b0;
      else tick_irq <= |irq_src;
`else
   assign tick_irq = 1'b0;
`endif
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: randomized tick_gen bench checked every cycle against a due-time scheduling model
module tb_tick_gen;
   localparam int NUM_CH    = 2;
   localparam int DIV_WIDTH = 16;
   localparam int DIV0_RST  = 380;
   localparam int DIVN_RST  = 216;
   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [NUM_CH-1:0] tick_pulse;
   logic [NUM_CH-1:0] tick_toggle;
   logic              tick_irq;
   tick_gen_if bus ();
   tick_gen #(
      .NUM_CH   (NUM_CH),
      .DIV_WIDTH(DIV_WIDTH),
      .DIV0_RST (DIV0_RST),
      .DIVN_RST (DIVN_RST)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .tick_pulse (tick_pulse),
      .tick_toggle(tick_toggle),
      .tick_irq   (tick_irq)
   );
   always #5 clock = ~clock;
   int n_chk  = 0;
   int n_pass = 0;
   // model: each enabled channel owns the absolute edge number of its next tick
   longint               n;
   logic [DIV_WIDTH-1:0] m_div  [NUM_CH];
   logic                 m_en   [NUM_CH];
   logic                 m_os   [NUM_CH];
   logic                 m_tog  [NUM_CH];
   logic                 m_pend [NUM_CH];
   logic                 m_ie   [NUM_CH];
   longint               m_due  [NUM_CH];
   logic [NUM_CH-1:0]    exp_pulse;
   logic [NUM_CH-1:0]    exp_tog;
   logic                 exp_ready;
   logic                 exp_irq;
   logic [31:0]          exp_rdata;
   longint               p0q[$];
   longint               p1q[$];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, n);
   endtask
   function automatic logic [31:0] ctrl_of(input int c);
`ifdef TICK_GEN_IRQ_EN
      return {27'd0, m_ie[c], m_pend[c], m_tog[c], m_os[c], m_en[c]};
`else
      return {29'd0, m_tog[c], m_os[c], m_en[c]};
`endif
   endfunction
   task automatic model_reset();
      n = 0;
      exp_pulse = '0;
      exp_tog = '0;
      exp_ready = 1'b0;
      exp_irq = 1'b0;
      exp_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_div[c]  = DIV_WIDTH'(c == 0 ? DIV0_RST : DIVN_RST);
         m_en[c]   = 1'b1;
         m_os[c]   = 1'b0;
         m_tog[c]  = 1'b0;
         m_pend[c] = 1'b0;
         m_ie[c]   = 1'b0;
         m_due[c]  = longint'(m_div[c]) + 1;
      end
   endtask
   task automatic model_step();
      logic        v, wr, irq;
      logic [31:0] a, d, tmp;
      logic [3:0]  s;
      int          ch;
      v  = bus.tick_valid;
      a  = bus.tick_addr;
      d  = bus.tick_wdata;
      s  = bus.tick_wstrb;
      wr = v && (s != 0);
      ch = int'(a[5:3]);
      n++;
      irq = 1'b0;
      for (int c = 0; c < NUM_CH; c++) irq = irq | (m_pend[c] & m_ie[c]);
      exp_irq   = irq;
      exp_ready = v;
      exp_rdata = '0;
      if (v && !wr && ch < NUM_CH) exp_rdata = a[2] ? ctrl_of(ch) : 32'(m_div[ch]);
      for (int c = 0; c < NUM_CH; c++) begin
         logic wd, wc, fire, pre_en;
         wd     = wr && ch == c && !a[2];
         wc     = wr && ch == c && a[2] && s[0];
         fire   = m_en[c] && n == m_due[c] && !wd && !(wc && !d[0]);
         pre_en = m_en[c];
         exp_pulse[c] = fire;
         if (fire) begin
            m_tog[c] = !m_tog[c];
            m_due[c] = n + longint'(m_div[c]) + 1;
            if (m_os[c]) m_en[c] = 1'b0;
`ifdef TICK_GEN_IRQ_EN
            m_pend[c] = 1'b1;
`endif
         end
         if (wd) begin
            tmp = 32'(m_div[c]);
            for (int b = 0; b < 4; b++) if (s[b]) tmp[8*b +: 8] = d[8*b +: 8];
            m_div[c] = DIV_WIDTH'(tmp);
            m_due[c] = n + longint'(m_div[c]) + 1;
         end
         if (wc) begin
            if (d[0] && !pre_en) m_due[c] = n + longint'(m_div[c]) + 1;
            m_en[c] = d[0];
            m_os[c] = d[1];
`ifdef TICK_GEN_IRQ_EN
            if (d[3] && !fire) m_pend[c] = 1'b0;
            m_ie[c] = d[4];
`endif
         end
         exp_tog[c] = m_tog[c];
      end
   endtask
   always @(posedge clock or posedge reset)
      if (reset) model_reset();
      else model_step();
   always @(negedge clock)
      if (!reset) begin
         chk("pulse", 32'(tick_pulse), 32'(exp_pulse));
         chk("toggle", 32'(tick_toggle), 32'(exp_tog));
         chk("ready", 32'(bus.tick_ready), 32'(exp_ready));
         chk("rdata", bus.tick_rdata, exp_rdata);
         chk("irq", 32'(tick_irq), 32'(exp_irq));
         if (tick_pulse[0]) p0q.push_back(n);
         if (tick_pulse[1]) p1q.push_back(n);
      end
   function automatic longint qget(input longint q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction
   task automatic wait_cyc(input longint t);
      while (n < t) @(negedge clock);
   endtask
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.tick_valid = 1'b1;
      bus.tick_addr  = a;
      bus.tick_wdata = d;
      bus.tick_wstrb = s;
      @(negedge clock);
      chk("wr_ready", 32'(bus.tick_ready), 32'd1);
      bus.tick_valid = 1'b0;
      bus.tick_wstrb = '0;
   endtask
   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      bus.tick_valid = 1'b1;
      bus.tick_addr  = a;
      bus.tick_wstrb = '0;
      @(negedge clock);
      chk("rd_ready", 32'(bus.tick_ready), 32'd1);
      d = bus.tick_rdata;
      bus.tick_valid = 1'b0;
   endtask
   task automatic chk_reset_outputs();
      chk("rst_pulse", 32'(tick_pulse), 32'd0);
      chk("rst_toggle", 32'(tick_toggle), 32'd0);
      chk("rst_ready", 32'(bus.tick_ready), 32'd0);
      chk("rst_rdata", bus.tick_rdata, 32'd0);
      chk("rst_irq", 32'(tick_irq), 32'd0);
   endtask
   task automatic do_reset();
      @(negedge clock);
      #3 reset = 1'b1;
      #1 chk_reset_outputs();
      @(negedge clock);
      #2 reset = 1'b0;
   endtask
   initial begin
      logic [31:0] d;
      longint      e;
      int          m0, m1, ch, sel;
      logic        t;
      bus.tick_valid = 1'b0;
      bus.tick_addr  = '0;
      bus.tick_wdata = '0;
      bus.tick_wstrb = '0;
      repeat (2) @(negedge clock);
      chk_reset_outputs();
      #2 reset = 1'b0;
      wait_cyc(500);
      chk("tog0_after_first_tick", 32'(tick_toggle[0]), 32'd1);
      wait_cyc(1150);
      chk("ch0_tick1", 32'(qget(p0q, 0)), 32'd381);
      chk("ch0_tick2", 32'(qget(p0q, 1)), 32'd762);
      chk("ch0_tick3", 32'(qget(p0q, 2)), 32'd1143);
      chk("ch1_tick1", 32'(qget(p1q, 0)), 32'd217);
      chk("ch1_tick2", 32'(qget(p1q, 1)), 32'd434);
      // ch1 is terminal on edge 1302; the DIV write lands exactly there
      wait_cyc(1301);
      m1 = p1q.size();
      bus_wr(32'h8, 32'd3, 4'hF);
      chk("div_wr_no_tick", 32'(tick_pulse[1]), 32'd0);
      wait_cyc(1316);
      chk("div3_tick1", 32'(qget(p1q, m1)), 32'd1306);
      chk("div3_tick2", 32'(qget(p1q, m1 + 1)), 32'd1310);
      chk("div3_tick3", 32'(qget(p1q, m1 + 2)), 32'd1314);
      bus_wr(32'h4, 32'd0, 4'hF);
      bus_wr(32'h0, 32'd5, 4'hF);
      m0 = p0q.size();
      bus_wr(32'h4, 32'd3, 4'h1);
      e = n;
      repeat (30) @(negedge clock);
      chk("oneshot_count", 32'(p0q.size() - m0), 32'd1);
      chk("oneshot_time", 32'(qget(p0q, m0)), 32'(e + 6));
      bus_rd(32'h4, d);
      chk("oneshot_ctrl", 32'(d[1:0]), 32'd2);
      bus_wr(32'h8, 32'd0, 4'hF);
      chk("div0_wr_edge", 32'(tick_pulse[1]), 32'd0);
      for (int i = 0; i < 4; i++) begin
         t = tick_toggle[1];
         @(negedge clock);
         chk("div0_pulse", 32'(tick_pulse[1]), 32'd1);
         chk("div0_toggle", 32'(tick_toggle[1]), 32'(!t));
      end
      bus_wr(32'hC, 32'd0, 4'h1);
      chk("en_clear_stop", 32'(tick_pulse[1]), 32'd0);
      @(negedge clock);
      chk("en_clear_stay", 32'(tick_pulse[1]), 32'd0);
      bus_rd(32'd40, d);
      chk("oor_read", d, 32'd0);
      bus_wr(32'd40, 32'hFFFF_FFFF, 4'hF);
      bus_wr(32'd44, 32'hFFFF_FFFF, 4'hF);
      bus_rd(32'h0, d);
      chk("div_ch0_kept", d, 32'd5);
      bus_rd(32'h8, d);
      chk("div_ch1_kept", d, 32'd0);
      bus_rd(32'hC, d);
      chk("ctrl_ch1_kept", 32'(d[1:0]), 32'd0);
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            bus.tick_valid = 1'b0;
            do_reset();
         end
         if ($urandom_range(0, 2) == 0) begin
            ch  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NUM_CH - 1));
            sel = int'($urandom_range(0, 1));
            bus.tick_valid = 1'b1;
            bus.tick_addr  = 32'(ch * 8 + sel * 4);
            bus.tick_wstrb = ($urandom_range(0, 4) < 2) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.tick_wdata = (sel == 1) ? (($urandom & 32'h1E) | 32'($urandom_range(0, 9) < 7))
                                        : 32'($urandom_range(0, 12));
         end else begin
            bus.tick_valid = 1'b0;
            bus.tick_wstrb = '0;
         end
         @(negedge clock);
      end
      bus.tick_valid = 1'b0;
      bus.tick_wstrb = '0;
`ifdef TICK_GEN_IRQ_EN
      do_reset();
      bus_wr(32'h0, 32'd2, 4'hF);
      bus_wr(32'h4, 32'h11, 4'h1);
      for (int i = 0; i < 20 && !tick_pulse[0]; i++) @(negedge clock);
      chk("irq_tick_cycle", 32'(n), 32'd4);
      chk("irq_at_tick", 32'(tick_irq), 32'd0);
      @(negedge clock);
      chk("irq_rise", 32'(tick_irq), 32'd1);
      bus_wr(32'h4, 32'h19, 4'h1);
      chk("irq_clear_edge", 32'(tick_irq), 32'd1);
      @(negedge clock);
      chk("irq_dropped", 32'(tick_irq), 32'd0);
      @(negedge clock);
      chk("irq_rerise", 32'(tick_irq), 32'd1);
      @(negedge clock);
      bus_wr(32'h4, 32'h19, 4'h1);
      chk("clear_on_tick_pulse", 32'(tick_pulse[0]), 32'd1);
      @(negedge clock);
      chk("clear_on_tick_irq", 32'(tick_irq), 32'd1);
`endif
      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
